loop_beat_sequencer: RTL

- Downstream consumer of the keyboard-driven loop width selector.
- Takes the selected loop width in measures (2..6), records one note vector per beat slot into an internal loop memory, and plays it back cyclically.
- Sits between the keyboard/control layer and the tone generator; beat timing comes from the tempo divider's beat_tick.

---
 rtl/loop_beat_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/loop_beat_sequencer.sv
// Beat-slot loop recorder/player; LOOP_OVERDUB_EN makes RECORD writes OR into the slot.
// note_out lags state/beat_pos by 1 cycle; buttons and beat_tick are never stalled.
module loop_beat_sequencer #(
  parameter int NOTE_W         = 8,
  parameter int BEATS_PER_MEAS = 4,
  parameter int MAX_WIDTH      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_tick,
  input  logic [2:0]        loop_width,
  input  logic              rec_btn,
  input  logic              play_btn,
  input  logic              clear_btn,
  input  logic [NOTE_W-1:0] note_in,
  output logic [NOTE_W-1:0] note_out,
  output logic [4:0]        beat_pos,
  output logic [2:0]        active_width,
  output logic              loop_start,
  output logic [1:0]        state,
  output logic              recorded
);

  localparam int         DEPTH     = MAX_WIDTH * BEATS_PER_MEAS;
  localparam logic [4:0] LAST_SLOT = 5'(DEPTH - 1);
  localparam logic [4:0] BPM       = 5'(BEATS_PER_MEAS);
  localparam logic [2:0] MAX_W     = 3'(MAX_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2,
    CLEAR  = 2'd3
  } st_t;

  st_t               st;
  logic [4:0]        clr_idx;
  logic [2:0]        pend_width;
  logic [NOTE_W-1:0] mem [DEPTH];

  logic              width_ok;
  logic [2:0]        width_nxt;
  logic [4:0]        loop_len;
  logic              at_end;
  logic              btn_clr;
  logic              btn_rec;
  logic              btn_play;
  logic              advance;
  logic              mem_we;
  logic [4:0]        mem_addr;
  logic [NOTE_W-1:0] mem_wdat;
  logic [NOTE_W-1:0] rec_dat;

  assign width_ok  = (loop_width >= 3'd2) && (loop_width <= MAX_W);
  assign width_nxt = width_ok ? loop_width : pend_width;
  assign loop_len  = {2'b00, active_width} * BPM;
  assign at_end    = (beat_pos == loop_len - 5'd1);

  // Any button that moves the FSM swallows the beat_tick of the same cycle.
  assign btn_clr  = clear_btn && (st != CLEAR);
  assign btn_rec  = rec_btn && !clear_btn && (st != CLEAR);
  assign btn_play = play_btn && !rec_btn && !clear_btn &&
                    (((st == IDLE) && recorded) || (st == PLAY));
  assign advance  = beat_tick && ((st == RECORD) || (st == PLAY)) &&
                    !btn_clr && !btn_rec && !btn_play;

`ifdef LOOP_OVERDUB_EN
  assign rec_dat = mem[beat_pos] | note_in;
`else
  assign rec_dat = note_in;
`endif

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = beat_pos;
    mem_wdat = rec_dat;
    if (!rst) begin
      if (st == CLEAR) begin
        mem_we   = 1'b1;
        mem_addr = clr_idx;
        mem_wdat = '0;
      end else if ((st == RECORD) && advance) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= CLEAR;
      clr_idx      <= 5'd0;
      beat_pos     <= 5'd0;
      active_width <= 3'd3;
      pend_width   <= 3'd3;
      note_out     <= '0;
      loop_start   <= 1'b0;
      recorded     <= 1'b0;
    end else begin
      loop_start <= 1'b0;

      case (st)
        PLAY:    note_out <= mem[beat_pos];
        RECORD:  note_out <= note_in;
        default: note_out <= '0;
      endcase

      case (st)
        CLEAR: begin
          if (clr_idx == LAST_SLOT) begin
            st      <= IDLE;
            clr_idx <= 5'd0;
          end else begin
            clr_idx <= clr_idx + 5'd1;
          end
        end

        IDLE: begin
          if (width_ok) active_width <= loop_width;
          pend_width <= width_ok ? loop_width : active_width;
          if (btn_clr) begin
            st       <= CLEAR;
            recorded <= 1'b0;
            clr_idx  <= 5'd0;
          end else if (btn_rec) begin
            st       <= RECORD;
            beat_pos <= 5'd0;
          end else if (btn_play) begin
            st       <= PLAY;
            beat_pos <= 5'd0;
          end
        end

        default: begin
          // Width changes only take effect at the loop seam.
          pend_width <= width_nxt;
          if (btn_clr) begin
            st       <= CLEAR;
            recorded <= 1'b0;
            clr_idx  <= 5'd0;
          end else if (btn_rec) begin
            if (st == RECORD) begin
              st       <= PLAY;
              recorded <= 1'b1;
              beat_pos <= 5'd0;
            end else begin
              st <= RECORD;
            end
          end else if (btn_play) begin
            st <= IDLE;
          end else if (advance) begin
            if (at_end) begin
              beat_pos     <= 5'd0;
              loop_start   <= 1'b1;
              active_width <= width_nxt;
              if (st == RECORD) begin
                st       <= PLAY;
                recorded <= 1'b1;
              end
            end else begin
              beat_pos <= beat_pos + 5'd1;
            end
          end
        end
      endcase
    end
  end

  assign state = st;

endmodule
